jtframe_scandbl: RTL

Parametrised line-doubling scan converter for 15 kHz arcade video cores targeting 31 kHz VGA outputs on MiST-class boards. It stores each input line in a double-banked line buffer and replays it twice at twice the pixel rate. It measures line length and sync width from the incoming stream instead of taking fixed constants, and adds selectable scanline dimming on the second replay. It sits between the game core's RGB/HS outputs and the frame module's VGA inputs, clocked by the system clock with pixel clock enables.

---
 rtl/jtframe_scandbl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/jtframe_scandbl.sv
// Line-doubling scan converter: buffers each input line in one bank of a double-banked
// line buffer and replays it twice at twice the pixel rate, with optional scanline dimming.
module jtframe_scandbl #(
   parameter int DW       = 8,
   parameter int RW       = 3,
   parameter int GW       = 3,
   parameter int BW       = 2,
   parameter int LINE_MAX = 512
) (
   input  logic                          rst_n,
   input  logic                          clk,
   input  logic                          base_cen,
   input  logic                          basex2_cen,
   input  logic [1:0]                    sl_mode,
   input  logic [DW-1:0]                 base_pxl,
   input  logic                          HS,
   output logic [DW-1:0]                 x2_pxl,
   output logic                          x2_HS,
   output logic                          x2_odd,
   output logic [$clog2(LINE_MAX):0]     line_len
);

   localparam int          AW   = $clog2(LINE_MAX);
   localparam logic [AW:0] LMAX = (AW+1)'(LINE_MAX);

   logic [DW-1:0] r_mem [2**(AW+1)];

   logic          r_hs_prev, r_wr_bank, r_seen1, r_valid, r_odd;
   logic [AW:0]   r_wr_addr, r_cnt, r_hs_cnt, r_hs_w, r_rd_addr;
   logic [1:0]    r_sl;
   logic [DW-1:0] r_pxl_p1;
   logic          r_odd_p1, r_hs_p1, r_vld_p1;
   logic [1:0]    r_sl_p1;

   logic          w_rise, w_fall, w_wrap, w_wr_en;
   logic [AW:0]   w_wr_idx, w_rd_idx;

   function automatic logic [DW-1:0] dim(input logic [DW-1:0] c, input logic [1:0] m);
      case (m)
         2'd1:    dim = c - (c >> 2);
         2'd2:    dim = c >> 1;
         2'd3:    dim = '0;
         default: dim = c;
      endcase
   endfunction

   function automatic logic [DW-1:0] scanline(input logic [DW-1:0] p, input logic [1:0] m);
      logic [DW-1:0] r, g, b;
      r = dim(DW'(p[DW-1 -: RW]), m);
      g = dim(DW'(p[DW-RW-1 -: GW]), m);
      b = dim(DW'(p[BW-1:0]), m);
      scanline = {r[RW-1:0], g[GW-1:0], b[BW-1:0]};
   endfunction

   assign w_rise   = base_cen & HS & ~r_hs_prev;
   assign w_fall   = base_cen & ~HS & r_hs_prev;
   assign w_wrap   = (r_rd_addr == line_len - (AW+1)'(1));
   assign w_wr_en  = base_cen & (w_rise | (r_wr_addr < LMAX));
   // The pixel carrying the HS edge already belongs to the new bank, at address 0
   assign w_wr_idx = w_rise ? {~r_wr_bank, AW'(0)} : {r_wr_bank, r_wr_addr[AW-1:0]};
   assign w_rd_idx = {~r_wr_bank, r_rd_addr[AW-1:0]};

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[w_wr_idx] <= base_pxl;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hs_prev <= 1'b0;
         r_wr_bank <= 1'b0;
         r_wr_addr <= '0;
         r_cnt     <= '0;
         r_hs_cnt  <= '0;
         r_hs_w    <= '0;
         line_len  <= '0;
         r_sl      <= 2'd0;
         r_seen1   <= 1'b0;
         r_valid   <= 1'b0;
      end else if (base_cen) begin
         r_hs_prev <= HS;
         if (w_rise) begin
            r_wr_bank <= ~r_wr_bank;
            r_wr_addr <= (AW+1)'(1);
            line_len  <= r_cnt;
            r_cnt     <= (AW+1)'(1);
            r_sl      <= sl_mode;
            r_seen1   <= 1'b1;
            r_valid   <= r_valid | r_seen1;
            r_hs_cnt  <= (AW+1)'(1);
         end else begin
            if (r_wr_addr < LMAX) r_wr_addr <= r_wr_addr + (AW+1)'(1);
            if (r_cnt < LMAX)     r_cnt     <= r_cnt + (AW+1)'(1);
            if (HS && r_hs_cnt < LMAX) r_hs_cnt <= r_hs_cnt + (AW+1)'(1);
         end
         if (w_fall) r_hs_w <= r_hs_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_addr <= '0;
         r_odd     <= 1'b0;
      end else if (w_rise) begin
         r_rd_addr <= '0;
         r_odd     <= 1'b0;
      end else if (basex2_cen) begin
         if (w_wrap) begin
            r_rd_addr <= '0;
            r_odd     <= ~r_odd;
         end else begin
            r_rd_addr <= r_rd_addr + (AW+1)'(1);
         end
      end
   end

   // p1: buffer read stage, control travels with the pixel
   always_ff @(posedge clk) begin
      if (basex2_cen) r_pxl_p1 <= r_mem[w_rd_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_odd_p1 <= 1'b0;
         r_hs_p1  <= 1'b0;
         r_sl_p1  <= 2'd0;
         r_vld_p1 <= 1'b0;
      end else if (basex2_cen) begin
         r_odd_p1 <= r_odd;
         r_hs_p1  <= (r_rd_addr < r_hs_w);
         r_sl_p1  <= r_sl;
         r_vld_p1 <= r_valid;
      end
   end

   always_comb begin
      x2_pxl = '0;
      x2_HS  = 1'b0;
      x2_odd = 1'b0;
      if (r_vld_p1) begin
         x2_pxl = scanline(r_pxl_p1, r_odd_p1 ? r_sl_p1 : 2'd0);
         x2_HS  = r_hs_p1;
         x2_odd = r_odd_p1;
      end
   end

endmodule
